// File: rtl/core_defs.sv
// Shared definitions for the core memory arbiter: FSM state encodings,
// transaction owner tags and SRAM access-size codes.
package core_defs;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } arb_owner_e;

  localparam logic [1:0] RAM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] RAM_SIZE_HALF = 2'b01;
  localparam logic [1:0] RAM_SIZE_WORD = 2'b10;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundle of the IF fetch port, MEM load/store port and SRAM master control
// port; master is the arbiter's view, slave is the pipeline/SRAM side.
interface core_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  logic              mem_req;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  logic              ram_en;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_size;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_done;

  logic              bus_err;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_done,
    input  mem_req, mem_wen, mem_addr, mem_size, mem_wdata,
    output mem_rdata, mem_done,
    output ram_en, ram_wen, ram_addr, ram_size, ram_din,
    input  ram_dout, ram_done,
    output bus_err
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_done,
    output mem_req, mem_wen, mem_addr, mem_size, mem_wdata,
    input  mem_rdata, mem_done,
    input  ram_en, ram_wen, ram_addr, ram_size, ram_din,
    output ram_dout, ram_done,
    input  bus_err
  );

endinterface

// File: rtl/core_arb_timer.sv
// Bus watchdog counter: cleared on load, counts enabled cycles and flags
// expiry during the LIMIT-th enabled cycle since the last load.
module core_arb_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter stops at LAST so a held-off expiry cannot wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/core_mem_arbiter.sv
// Sequential IF/MEM arbiter onto the single SRAM master port: one owned
// transaction at a time, MEM priority with IF starvation bound, bus watchdog.
module core_mem_arbiter
  import core_defs::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                rst_n,
  core_mem_arbiter_if.master bus
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              drop_q, drop_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [1:0]        ram_size_q, ram_size_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic              bus_err_q, bus_err_d;

  logic              grant_mem_s;
  logic              grant_if_s;
  logic              busy_s;
  logic              expire_s;
  logic              finish_s;
  logic              timeout_s;
  logic              if_flush_hit_s;
  logic [DATA_W-1:0] rdata_s;

  core_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (grant_mem_s || grant_if_s),
    .en_i     (busy_s),
    .expire_o (expire_s)
  );

  // MEM wins unless IF has already been passed over STARVE_LIMIT times.
  always_comb begin
    grant_mem_s = 1'b0;
    grant_if_s  = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (bus.mem_req && (starve_cnt_q < STARVE_MAX)) begin
        grant_mem_s = 1'b1;
      end else if (bus.if_req && !bus.if_flush) begin
        grant_if_s = 1'b1;
      end else begin
        grant_mem_s = bus.mem_req;
      end
    end else begin
      grant_mem_s = 1'b0;
      grant_if_s  = 1'b0;
    end
  end

  // ram_done takes precedence over a watchdog expiry in the same cycle.
  assign busy_s         = (state_q == ARB_BUSY);
  assign finish_s       = busy_s && (bus.ram_done || expire_s);
  assign timeout_s      = busy_s && !bus.ram_done && expire_s;
  assign if_flush_hit_s = (owner_q == OWNER_IF) && bus.if_flush && (state_q != ARB_IDLE);
  assign rdata_s        = bus.ram_done ? bus.ram_dout : {DATA_W{1'b0}};

  always_comb begin
    if (grant_if_s || !bus.if_req) begin
      starve_cnt_d = {SC_W{1'b0}};
    end else if (grant_mem_s && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: state_d = (grant_mem_s || grant_if_s) ? ARB_BUSY : ARB_IDLE;
      ARB_BUSY: state_d = finish_s ? ARB_RESP : ARB_BUSY;
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Done pulses are set on the BUSY->RESP edge so they are high for the RESP cycle.
  always_comb begin
    owner_d     = owner_q;
    drop_d      = drop_q;
    ram_en_d    = ram_en_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_size_d  = ram_size_q;
    ram_din_d   = ram_din_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    bus_err_d   = bus_err_q;
    if (grant_mem_s) begin
      owner_d    = OWNER_MEM;
      drop_d     = 1'b0;
      ram_en_d   = 1'b1;
      ram_wen_d  = bus.mem_wen;
      ram_addr_d = bus.mem_addr;
      ram_size_d = bus.mem_size;
      ram_din_d  = bus.mem_wdata;
    end else if (grant_if_s) begin
      owner_d    = OWNER_IF;
      drop_d     = 1'b0;
      ram_en_d   = 1'b1;
      ram_wen_d  = 1'b0;
      ram_addr_d = bus.if_addr;
      ram_size_d = RAM_SIZE_WORD;
      ram_din_d  = {DATA_W{1'b0}};
    end else if (finish_s) begin
      ram_en_d  = 1'b0;
      bus_err_d = bus_err_q || timeout_s;
      if (owner_q == OWNER_MEM) begin
        mem_done_d  = 1'b1;
        mem_rdata_d = rdata_s;
      end else if (!(drop_q || bus.if_flush)) begin
        if_done_d  = 1'b1;
        if_rdata_d = rdata_s;
      end else begin
        drop_d = 1'b1;
      end
    end else if (if_flush_hit_s) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWNER_IF;
      drop_q       <= 1'b0;
      starve_cnt_q <= {SC_W{1'b0}};
      ram_en_q     <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_addr_q   <= {ADDR_W{1'b0}};
      ram_size_q   <= 2'b00;
      ram_din_q    <= {DATA_W{1'b0}};
      if_rdata_q   <= {DATA_W{1'b0}};
      mem_rdata_q  <= {DATA_W{1'b0}};
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      drop_q       <= drop_d;
      starve_cnt_q <= starve_cnt_d;
      ram_en_q     <= ram_en_d;
      ram_wen_q    <= ram_wen_d;
      ram_addr_q   <= ram_addr_d;
      ram_size_q   <= ram_size_d;
      ram_din_q    <= ram_din_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_done_q    <= if_done_d;
      mem_done_q   <= mem_done_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_size  = ram_size_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed self-checking bench for core_mem_arbiter; the bench plays both
// the pipeline requesters and the SRAM master, all driven on falling edges.
module tb_core_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  core_mem_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000 ns");
    $fatal(1);
  end

  // Waits (bounded) for ram_en to be seen high on a falling edge.
  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.ram_en === 1'b1) ok = 1'b1;
    end
  endtask

  // Returns ram_done+dout after 'delay' cycles; ends on the negedge where done should be visible.
  task automatic respond(input int delay, input logic [31:0] dout);
    repeat (delay) @(negedge clk);
    bus.ram_done = 1'b1;
    bus.ram_dout = dout;
    @(negedge clk);
    bus.ram_done = 1'b0;
    bus.ram_dout = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_wen = 1'b0; bus.mem_addr = 32'h0;
    bus.mem_size = 2'b00; bus.mem_wdata = 32'h0;
    bus.ram_dout = 32'h0; bus.ram_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.ram_en !== 1'b0) begin fails++; $display("FAIL reset_ram_en: got %b want 0", bus.ram_en); end
    checks++; if ({bus.if_done, bus.mem_done, bus.bus_err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {bus.if_done, bus.mem_done, bus.bus_err}); end
    checks++; if (bus.ram_addr !== 32'h0 || bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0) begin fails++; $display("FAIL reset_data: addr %h ifr %h memr %h want 0", bus.ram_addr, bus.if_rdata, bus.mem_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_if_only();
    bit ok;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    wait_en(ok);
    checks++; if (!ok) begin fails++; $display("FAIL if_only_grant: ram_en never rose"); end
    checks++; if (bus.ram_addr !== 32'h100) begin fails++; $display("FAIL if_only_addr: got %h want 00000100", bus.ram_addr); end
    checks++; if (bus.ram_size !== 2'b10 || bus.ram_wen !== 1'b0) begin fails++; $display("FAIL if_only_attr: size %b wen %b want 10 0", bus.ram_size, bus.ram_wen); end
    respond(2, 32'h00000013);
    checks++; if (bus.if_done !== 1'b1 || bus.mem_done !== 1'b0) begin fails++; $display("FAIL if_only_done: if_done %b mem_done %b want 1 0", bus.if_done, bus.mem_done); end
    checks++; if (bus.if_rdata !== 32'h13) begin fails++; $display("FAIL if_only_rdata: got %h want 00000013", bus.if_rdata); end
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.if_done !== 1'b0 || bus.ram_en !== 1'b0) begin fails++; $display("FAIL if_only_pulse: if_done %b ram_en %b want 0 0", bus.if_done, bus.ram_en); end
  endtask

  task automatic test_spurious_done();
    bus.ram_done = 1'b1; bus.ram_dout = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.ram_done = 1'b0; bus.ram_dout = 32'h0;
    @(negedge clk);
    checks++; if ({bus.if_done, bus.mem_done, bus.ram_en} !== 3'b000) begin fails++; $display("FAIL spurious_done: if/mem/en %b want 000", {bus.if_done, bus.mem_done, bus.ram_en}); end
    checks++; if (bus.if_rdata !== 32'h13) begin fails++; $display("FAIL spurious_rdata: got %h want 00000013", bus.if_rdata); end
  endtask

  task automatic test_priority();
    bit ok;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.mem_req = 1'b1; bus.mem_wen = 1'b1; bus.mem_addr = 32'h2000;
    bus.mem_size = 2'b10; bus.mem_wdata = 32'hDEADBEEF;
    wait_en(ok);
    checks++; if (!ok) begin fails++; $display("FAIL prio_grant1: ram_en never rose"); end
    checks++; if (bus.ram_wen !== 1'b1 || bus.ram_din !== 32'hDEADBEEF || bus.ram_addr !== 32'h2000) begin fails++; $display("FAIL prio_mem_attr: wen %b din %h addr %h want 1 deadbeef 00002000", bus.ram_wen, bus.ram_din, bus.ram_addr); end
    respond(1, 32'h0);
    checks++; if (bus.mem_done !== 1'b1 || bus.if_done !== 1'b0) begin fails++; $display("FAIL prio_mem_done: mem_done %b if_done %b want 1 0", bus.mem_done, bus.if_done); end
    bus.mem_req = 1'b0;
    wait_en(ok);
    checks++; if (!ok) begin fails++; $display("FAIL prio_grant2: ram_en never rose"); end
    checks++; if (bus.ram_addr !== 32'h104 || bus.ram_wen !== 1'b0 || bus.ram_din !== 32'h0) begin fails++; $display("FAIL prio_if_attr: addr %h wen %b din %h want 00000104 0 0", bus.ram_addr, bus.ram_wen, bus.ram_din); end
    respond(1, 32'h00000093);
    checks++; if (bus.if_done !== 1'b1 || bus.mem_done !== 1'b0 || bus.if_rdata !== 32'h93) begin fails++; $display("FAIL prio_if_done: if_done %b mem_done %b rdata %h want 1 0 00000093", bus.if_done, bus.mem_done, bus.if_rdata); end
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bit ok;
    logic [31:0] exp_addr;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.mem_req = 1'b1; bus.mem_wen = 1'b0; bus.mem_addr = 32'h3000; bus.mem_size = 2'b10;
    for (int g = 0; g < 5; g++) begin
      exp_addr = (g < 4) ? 32'h3000 : 32'h200;
      wait_en(ok);
      checks++; if (!ok || bus.ram_addr !== exp_addr) begin fails++; $display("FAIL starve_grant%0d: en_ok %b addr %h want %h", g, ok, bus.ram_addr, exp_addr); end
      respond(0, 32'h1000 + g);
      checks++; if ({bus.mem_done, bus.if_done} !== ((g < 4) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL starve_done%0d: mem/if %b want %b", g, {bus.mem_done, bus.if_done}, (g < 4) ? 2'b10 : 2'b01); end
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    checks++; if (bus.if_rdata !== 32'h1004 || bus.mem_rdata !== 32'h1003) begin fails++; $display("FAIL starve_rdata: if %h mem %h want 00001004 00001003", bus.if_rdata, bus.mem_rdata); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit ok;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    wait_en(ok);
    checks++; if (!ok) begin fails++; $display("FAIL flush_grant: ram_en never rose"); end
    bus.if_flush = 1'b1;
    @(negedge clk);
    bus.if_flush = 1'b0; bus.if_req = 1'b0;
    checks++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== 32'h300) begin fails++; $display("FAIL flush_hold: en %b addr %h want 1 00000300", bus.ram_en, bus.ram_addr); end
    respond(1, 32'hAA);
    checks++; if (bus.if_done !== 1'b0 || bus.mem_done !== 1'b0 || bus.ram_en !== 1'b0) begin fails++; $display("FAIL flush_suppress: if_done %b mem_done %b en %b want 0 0 0", bus.if_done, bus.mem_done, bus.ram_en); end
    checks++; if (bus.if_rdata !== 32'h1004) begin fails++; $display("FAIL flush_rdata: got %h want 00001004", bus.if_rdata); end
    bus.if_req = 1'b1; bus.if_addr = 32'h304;
    wait_en(ok);
    checks++; if (!ok || bus.ram_addr !== 32'h304) begin fails++; $display("FAIL flush_next_grant: en_ok %b addr %h want 00000304", ok, bus.ram_addr); end
    respond(1, 32'h55);
    checks++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h55) begin fails++; $display("FAIL flush_next_done: done %b rdata %h want 1 00000055", bus.if_done, bus.if_rdata); end
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    bus.mem_req = 1'b1; bus.mem_wen = 1'b0; bus.mem_addr = 32'h4000; bus.mem_size = 2'b00;
    wait_en(ok);
    checks++; if (!ok || bus.ram_size !== 2'b00) begin fails++; $display("FAIL timeout_grant: en_ok %b size %b want 1 00", ok, bus.ram_size); end
    repeat (254) @(negedge clk);
    checks++; if (bus.ram_en !== 1'b1 || bus.bus_err !== 1'b0 || bus.mem_done !== 1'b0) begin fails++; $display("FAIL timeout_early: en %b err %b done %b want 1 0 0", bus.ram_en, bus.bus_err, bus.mem_done); end
    @(negedge clk);
    checks++; if (bus.ram_en !== 1'b0 || bus.bus_err !== 1'b1) begin fails++; $display("FAIL timeout_abort: en %b err %b want 0 1", bus.ram_en, bus.bus_err); end
    checks++; if (bus.mem_done !== 1'b1 || bus.mem_rdata !== 32'h0 || bus.if_done !== 1'b0) begin fails++; $display("FAIL timeout_done: mem_done %b rdata %h if_done %b want 1 0 0", bus.mem_done, bus.mem_rdata, bus.if_done); end
    bus.mem_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.bus_err !== 1'b1 || bus.mem_done !== 1'b0) begin fails++; $display("FAIL timeout_sticky: err %b done %b want 1 0", bus.bus_err, bus.mem_done); end
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    wait_en(ok);
    checks++; if (!ok) begin fails++; $display("FAIL rstbusy_grant: ram_en never rose"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.ram_en !== 1'b0 || bus.bus_err !== 1'b0) begin fails++; $display("FAIL rstbusy_async: en %b err %b want 0 0", bus.ram_en, bus.bus_err); end
    @(negedge clk);
    checks++; if (bus.if_done !== 1'b0 || bus.mem_done !== 1'b0) begin fails++; $display("FAIL rstbusy_nodone: if %b mem %b want 0 0", bus.if_done, bus.mem_done); end
    rst_n = 1'b1;
    wait_en(ok);
    checks++; if (!ok || bus.ram_addr !== 32'h500) begin fails++; $display("FAIL rstbusy_regrant: en_ok %b addr %h want 00000500", ok, bus.ram_addr); end
    respond(1, 32'h77);
    checks++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h77) begin fails++; $display("FAIL rstbusy_fetch: done %b rdata %h want 1 00000077", bus.if_done, bus.if_rdata); end
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_if_only();
    test_spurious_done();
    test_priority();
    test_starvation();
    test_flush();
    test_timeout();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
